net_out_serialiser: RTL



---
 rtl/net_out_serialiser_pkg.sv | 34 +++
 rtl/net_out_serialiser_if.sv | 28 ++
 rtl/net_out_serialiser_frame_fifo.sv | 52 +++++
 rtl/net_out_serialiser.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/net_out_serialiser_pkg.sv
// Shared widths, frame type and the shift-and-clamp helper for the
// network output serialiser.
//   NET_W / NET_OUT_W / NET_DROP / NET_DEPTH : default parameters
//   frame_t   : one 4-channel network output frame, channel 0 in the low slot
//   sat_shift : arithmetic right shift followed by saturation to out_w bits
package net_out_serialiser_pkg;

   localparam int unsigned NET_W     = 16;
   localparam int unsigned NET_OUT_W = 12;
   localparam int unsigned NET_DROP  = 4;
   localparam int unsigned NET_DEPTH = 4;
   localparam int unsigned NET_CHANS = 4;

   typedef logic [NET_CHANS-1:0][NET_W-1:0] frame_t;

   // Shift then clamp into the signed out_w range; the result is still
   // 32 bits wide and the caller truncates it to out_w.
   function automatic logic signed [31:0] sat_shift(
      input logic signed [31:0] x,
      input int unsigned        drop,
      input int unsigned        out_w
   );
      logic signed [31:0] s;
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      s  = x >>> drop;
      hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (out_w - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/net_out_serialiser_if.sv
// Valid/ready sample stream leaving the serialiser.
//   m_data  : signed sample, OUT_W bits
//   m_chan  : channel index of m_data
//   m_last  : high on the channel-3 beat
//   m_valid : source has a sample
//   m_ready : sink accepts the sample
// master = serialiser side, slave = sink side.
interface net_out_serialiser_if
   import net_out_serialiser_pkg::*;
#(
   parameter int unsigned OUT_W = NET_OUT_W
);
   logic signed [OUT_W-1:0] m_data;
   logic [1:0]              m_chan;
   logic                    m_last;
   logic                    m_valid;
   logic                    m_ready;

   modport master (
      output m_data, m_chan, m_last, m_valid,
      input  m_ready
   );

   modport slave (
      input  m_data, m_chan, m_last, m_valid,
      output m_ready
   );
endinterface

// File: rtl/net_out_serialiser_frame_fifo.sv
// Frame FIFO between network capture and the serialiser.
//   clk, rst_n : clock, synchronous active-low reset (pointers only)
//   i_push     : write i_data (caller guarantees space or a same-cycle pop)
//   i_data     : frame payload
//   i_pop      : drop the head frame (caller guarantees not empty)
//   o_head_c   : head frame, combinational from storage
//   o_full_c, o_empty_c, o_count_c : occupancy, combinational from pointers
module net_out_serialiser_frame_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_data,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_head_c,
   output logic                     o_full_c,
   output logic                     o_empty_c,
   output logic [$clog2(DEPTH):0]   o_count_c
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
   end

   // Storage is not reset; empty pointers make stale contents unreachable.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
   end

   assign o_head_c  = r_mem[r_rd_ptr[ADDR_W-1:0]];
   assign o_empty_c = (r_wr_ptr == r_rd_ptr);
   assign o_full_c  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                      (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
   assign o_count_c = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/net_out_serialiser.sv
// Captures 4-channel network output frames on the rising edge of in_v,
// buffers them in a frame FIFO and emits the rescaled channels one per beat.
//   clk, rst_n        : clock, synchronous active-low reset
//   in_d0..in_d3      : signed network output channels
//   in_v              : network output valid (only its rising edge captures)
//   m_if (master)     : m_data/m_chan/m_last/m_valid out, m_ready in
//   fifo_count        : frames stored and not yet loaded into the serialiser
//   overflow          : sticky, a frame has been dropped since reset
//   drop_cnt          : dropped-frame count, saturating at 255
module net_out_serialiser
   import net_out_serialiser_pkg::*;
#(
   parameter int unsigned W     = NET_W,
   parameter int unsigned OUT_W = NET_OUT_W,
   parameter int unsigned DROP  = NET_DROP,
   parameter int unsigned DEPTH = NET_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic signed [W-1:0]      in_d0,
   input  logic signed [W-1:0]      in_d1,
   input  logic signed [W-1:0]      in_d2,
   input  logic signed [W-1:0]      in_d3,
   input  logic                     in_v,
   net_out_serialiser_if.master     m_if,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic [7:0]               drop_cnt
);

   localparam int unsigned FRAME_W = NET_CHANS * W;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   // Capture side
   logic                          r_in_v_q;
   logic                          w_push;
   logic                          w_fifo_push;
   logic                          w_drop;
   logic                          r_overflow;
   logic [7:0]                    r_drop_cnt;

   // FIFO side
   logic [NET_CHANS-1:0][W-1:0]   w_in_frame;
   logic [NET_CHANS-1:0][W-1:0]   w_head;
   logic [FRAME_W-1:0]            w_head_flat;
   logic                          w_full;
   logic                          w_empty;
   logic [$clog2(DEPTH):0]        w_count;
   logic                          w_pop;

   // Serialiser side
   logic [NET_CHANS-1:0][OUT_W-1:0] w_scaled;
   logic [0:0]                    r_state;
   logic [0:0]                    w_state_nxt;
   logic                          r_m_valid;
   logic                          w_valid_nxt;
   logic [OUT_W-1:0]              r_m_data;
   logic [OUT_W-1:0]              w_data_nxt;
   logic [1:0]                    r_m_chan;
   logic [1:0]                    w_chan_nxt;
   logic                          r_m_last;
   logic                          w_last_nxt;
   logic [2:0][OUT_W-1:0]         r_sr;
   logic [2:0][OUT_W-1:0]         w_sr_nxt;

   assign w_in_frame = {in_d3, in_d2, in_d1, in_d0};

   // A level held high yields one frame: only the low-to-high transition pushes.
   assign w_push      = in_v & ~r_in_v_q;
   assign w_fifo_push = w_push & (~w_full | w_pop);
   assign w_drop      = w_push & w_full & ~w_pop;

   net_out_serialiser_frame_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (FRAME_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_push    (w_fifo_push),
      .i_data    (w_in_frame),
      .i_pop     (w_pop),
      .o_head_c  (w_head_flat),
      .o_full_c  (w_full),
      .o_empty_c (w_empty),
      .o_count_c (w_count)
   );

   assign w_head = w_head_flat;

   // Rescale the head frame as it is popped.
   always_comb begin
      w_scaled = '0;
      for (int k = 0; k < NET_CHANS; k++) begin
         w_scaled[k] = OUT_W'(sat_shift(32'(signed'(w_head[k])), DROP, OUT_W));
      end
   end

   // Serialiser next-state and outputs; a pop always reloads the shift
   // register and presents channel 0 on the following cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_valid_nxt = r_m_valid;
      w_data_nxt  = r_m_data;
      w_chan_nxt  = r_m_chan;
      w_last_nxt  = r_m_last;
      w_sr_nxt    = r_sr;
      w_pop       = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (!w_empty) w_pop = 1'b1;
         end
         S_SEND: begin
            if (r_m_valid && m_if.m_ready) begin
               if (r_m_chan != 2'd3) begin
                  w_data_nxt  = r_sr[0];
                  w_sr_nxt[0] = r_sr[1];
                  w_sr_nxt[1] = r_sr[2];
                  w_sr_nxt[2] = '0;
                  w_chan_nxt  = r_m_chan + 2'd1;
                  w_last_nxt  = (r_m_chan == 2'd2);
               end else if (!w_empty) begin
                  w_pop = 1'b1;
               end else begin
                  w_valid_nxt = 1'b0;
                  w_last_nxt  = 1'b0;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase

      if (w_pop) begin
         w_state_nxt = S_SEND;
         w_valid_nxt = 1'b1;
         w_chan_nxt  = 2'd0;
         w_last_nxt  = 1'b0;
         w_data_nxt  = w_scaled[0];
         w_sr_nxt    = w_scaled[3:1];
      end
   end

   // Serialiser and capture registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_chan  <= 2'd0;
         r_m_last  <= 1'b0;
         r_sr      <= '0;
         r_in_v_q  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_m_valid <= w_valid_nxt;
         r_m_data  <= w_data_nxt;
         r_m_chan  <= w_chan_nxt;
         r_m_last  <= w_last_nxt;
         r_sr      <= w_sr_nxt;
         r_in_v_q  <= in_v;
      end
   end

   // Drop accounting
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_overflow <= 1'b0;
         r_drop_cnt <= 8'd0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
   end

   assign m_if.m_valid = r_m_valid;
   assign m_if.m_data  = r_m_data;
   assign m_if.m_chan  = r_m_chan;
   assign m_if.m_last  = r_m_last;
   assign fifo_count   = w_count;
   assign overflow     = r_overflow;
   assign drop_cnt     = r_drop_cnt;

endmodule
